// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch engine for the multicycle MIPS datapath. Owns PC, nPC,
// MAR and IR. A fetch_go from the control unit latches PC into MAR and reads
// the word with the MOV/MOC handshake. The word is loaded into IR. PC then
// advances to nPC, and nPC advances to nPC+PC_STEP or to a captured branch
// target. This gives delayed-branch semantics: the delay slot is always
// fetched.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   fetch_go         start a fetch (sampled only while idle)
//   branch_take      capture branch_target as the next nPC
//   branch_target    branch destination
//   fault_clr        leave the fault state
//   mem_moc          memory operation complete
//   mem_rdata        memory read data, valid with mem_moc
//   mem_mov          read request valid
//   mem_rw           always 1 (read)
//   mar, ir, pc, npc architectural registers
//   busy             engine not idle
//   fetch_done       one-cycle pulse: IR valid, PC/nPC advance at next edge
//   fault            memory timeout fault
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned MOC_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_go,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              fault_clr,
  input  logic              mem_moc,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              busy,
  output logic              fetch_done,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_UPDATE = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  // The wait counter only has to reach MOC_TIMEOUT-1.
  localparam int CNT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] NPC_RST  = PC_RST + STEP;
  localparam logic              TO_EN    = (MOC_TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'((MOC_TIMEOUT == 32'd0) ? 32'd0 : MOC_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   npc_q, npc_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      npc_q   <= NPC_RST;
      mar_q   <= '0;
      ir_q    <= '0;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;

    // Branch capture. UPDATE consumes branch_take directly below, and FAULT
    // ignores it while keeping any branch that is already pending.
    if (branch_take && (state_q == S_IDLE || state_q == S_REQ)) begin
      pend_d = 1'b1;
      tgt_d  = branch_target;
    end else begin
      pend_d = pend_q;
      tgt_d  = tgt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fetch_go) begin
          mar_d   = pc_q;
          wait_d  = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_moc) begin
          ir_d    = mem_rdata;
          state_d = S_UPDATE;
        end else if (TO_EN && (wait_q == TO_LAST)) begin
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + CNT_ONE;
          state_d = S_REQ;
        end
      end
      S_UPDATE: begin
        pc_d = npc_q;
        // A branch asserted in this very cycle wins over an older pending one.
        if (branch_take) begin
          npc_d = branch_target;
        end else if (pend_q) begin
          npc_d = tgt_q;
        end else begin
          npc_d = npc_q + STEP;
        end
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs are decoded from the registered state only.
  assign mem_mov    = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE);
  assign fetch_done = (state_q == S_UPDATE);
  assign fault      = (state_q == S_FAULT);
  assign mem_rw     = 1'b1;
  assign mar        = mar_q;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign npc        = npc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_go = 1'b0, branch_take = 1'b0, fault_clr = 1'b0, mem_moc = 1'b0;
  logic [31:0] branch_target = 32'h0, mem_rdata = 32'h0;
  logic        mem_mov, mem_rw, busy, fetch_done, fault;
  logic [31:0] mar, ir, pc, npc;

  // Second, narrow instance for the address-wrap scenario.
  logic        go8 = 1'b0, moc8 = 1'b0;
  logic [31:0] rdata8 = 32'h0;
  logic        mov8, rw8, busy8, done8, fault8;
  logic [7:0]  mar8, pc8, npc8;
  logic [31:0] ir8;

  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;
  int mov_cnt  = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_go(fetch_go), .branch_take(branch_take),
    .branch_target(branch_target), .fault_clr(fault_clr), .mem_moc(mem_moc),
    .mem_rdata(mem_rdata), .mem_mov(mem_mov), .mem_rw(mem_rw), .mar(mar), .ir(ir),
    .pc(pc), .npc(npc), .busy(busy), .fetch_done(fetch_done), .fault(fault)
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .RESET_PC(32'hF8), .PC_STEP(4), .MOC_TIMEOUT(15)) dut8 (
    .clk(clk), .reset(reset), .fetch_go(go8), .branch_take(1'b0),
    .branch_target(8'h00), .fault_clr(1'b0), .mem_moc(moc8),
    .mem_rdata(rdata8), .mem_mov(mov8), .mem_rw(rw8), .mar(mar8), .ir(ir8),
    .pc(pc8), .npc(npc8), .busy(busy8), .fetch_done(done8), .fault(fault8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for memory, 2 reporting done, 3 faulted
  localparam int TIMEOUT = 15;
  int          m_phase;
  int          m_req_cycles;
  logic [31:0] m_pc, m_npc, m_mar, m_ir, m_tgt;
  bit          m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_req_cycles = 0; m_pend = 0; m_tgt = 0;
      m_pc = 32'h0; m_npc = 32'h4; m_mar = 32'h0; m_ir = 32'h0;
    end else begin
      int ph;
      ph = m_phase;
      if (branch_take && (ph == 0 || ph == 1)) begin
        m_pend = 1; m_tgt = branch_target;
      end
      if (ph == 0 && fetch_go) begin
        m_mar = m_pc; m_req_cycles = 1; m_phase = 1;
      end else if (ph == 1) begin
        if (mem_moc) begin
          m_ir = mem_rdata; m_phase = 2;
        end else if (m_req_cycles >= TIMEOUT) begin
          m_phase = 3;
        end else begin
          m_req_cycles++;
        end
      end else if (ph == 2) begin
        m_pc = m_npc;
        m_npc = branch_take ? branch_target : (m_pend ? m_tgt : m_npc + 32'd4);
        m_pend = 0;
        m_phase = 0;
      end else if (ph == 3 && fault_clr) begin
        m_phase = 0;
      end
    end
  end

  // Compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("npc", npc, m_npc);
    chk("mar", mar, m_mar);
    chk("ir", ir, m_ir);
    chk("mem_mov", mem_mov, m_phase == 1);
    chk("mem_rw", mem_rw, 1'b1);
    chk("busy", busy, m_phase != 0);
    chk("fetch_done", fetch_done, m_phase == 2);
    chk("fault", fault, m_phase == 3);
    if (fetch_done) done_cnt++;
    if (mem_mov) mov_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input int waits, input logic [31:0] data);
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    repeat (waits) tick();
    mem_moc = 1'b1; mem_rdata = data; tick(); mem_moc = 1'b0;
    tick();
  endtask

  task automatic fetch8(input logic [31:0] data);
    go8 = 1'b1; tick(); go8 = 1'b0;
    moc8 = 1'b1; rdata8 = data; tick(); moc8 = 1'b0;
    tick();
  endtask

  initial begin
    int d0;
    #1 reset = 1'b1;
    tick(); tick();
    // Reset values
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", npc, 32'h4);
    chk("rst_ir", ir, 32'h0);
    chk("rst_mov", mem_mov, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_pc8", pc8, 8'hF8);
    chk("rst_npc8", npc8, 8'hFC);
    reset = 1'b0;
    tick();

    // Zero-wait fetch
    done_cnt = 0;
    fetch(0, 32'h8C220004);
    chk("f1_mar", mar, 32'h0);
    chk("f1_ir", ir, 32'h8C220004);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_pc", pc, 32'h4);
    chk("f1_npc", npc, 32'h8);

    // Three memory wait cycles
    mov_cnt = 0;
    fetch(3, 32'h8C220004);
    chk("f2_mov_cycles", mov_cnt, 4);
    chk("f2_ir", ir, 32'h8C220004);
    chk("f2_fault", fault, 1'b0);
    chk("f2_pc", pc, 32'h8);
    chk("f2_npc", npc, 32'hC);

    // Branch during REQ: delay slot fetched next
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    branch_take = 1'b1; branch_target = 32'h40; tick(); branch_take = 1'b0;
    mem_moc = 1'b1; mem_rdata = 32'h1000FFFF; tick(); mem_moc = 1'b0;
    tick();
    chk("br_pc", pc, 32'hC);
    chk("br_npc", npc, 32'h40);
    fetch(0, 32'h00000000);
    chk("br2_pc", pc, 32'h40);
    chk("br2_npc", npc, 32'h44);

    // Branch asserted during the UPDATE cycle itself
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    mem_moc = 1'b1; mem_rdata = 32'h24420001; tick(); mem_moc = 1'b0;
    branch_take = 1'b1; branch_target = 32'h100; tick(); branch_take = 1'b0;
    chk("bu_pc", pc, 32'h44);
    chk("bu_npc", npc, 32'h100);
    chk("bu_ir", ir, 32'h24420001);

    // MOC timeout -> fault
    mov_cnt = 0;
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    repeat (20) tick();
    chk("to_mov_cycles", mov_cnt, 15);
    chk("to_fault", fault, 1'b1);
    chk("to_mov", mem_mov, 1'b0);
    chk("to_pc", pc, 32'h44);
    chk("to_mar", mar, 32'h44);
    // branch in FAULT is ignored
    branch_take = 1'b1; branch_target = 32'h200; tick(); branch_take = 1'b0;
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("clr_fault", fault, 1'b0);
    chk("clr_busy", busy, 1'b0);
    fetch(1, 32'hAABBCCDD);
    chk("rt_mar", mar, 32'h44);
    chk("rt_pc", pc, 32'h100);
    chk("rt_npc", npc, 32'h104);
    chk("rt_ir", ir, 32'hAABBCCDD);

    // Address wrap on the 8-bit instance
    fetch8(32'h11111111);
    chk("w1_pc8", pc8, 8'hFC);
    chk("w1_npc8", npc8, 8'h00);
    fetch8(32'h22222222);
    chk("w2_pc8", pc8, 8'h00);
    chk("w2_npc8", npc8, 8'h04);
    chk("w2_ir8", ir8, 32'h22222222);

    // Reset pulsed mid-REQ aborts without a done pulse
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("mr_pc", pc, 32'h0);
    chk("mr_npc", npc, 32'h4);
    chk("mr_ir", ir, 32'h0);
    chk("mr_mov", mem_mov, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", fetch_done, 1'b0);
    tick();
    reset = 1'b0;
    mem_moc = 1'b1; tick(); mem_moc = 1'b0;
    tick();
    chk("mr_no_done", done_cnt, d0);
    chk("mr_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
